// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision sequential adder: chunk width,
// sequencer states and the chunk-count helper.
package mp_add_pkg;

    localparam int CHUNK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    function automatic int nchunk(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/prefix_adder.sv
// 8-bit Kogge-Stone prefix adder with carry-in; the chunk datapath of mp_add_seq.
module prefix_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g [0:3];
    logic [7:0] p [0:3];
    logic [7:0] c;

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int l = 1; l < 4; l++) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= (1 << (l - 1))) begin
                    g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
                    p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
                end else begin
                    g[l][i] = g[l-1][i];
                    p[l][i] = p[l-1][i];
                end
            end
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0] with cin folded in.
    assign c    = {g[3][6:0] | (p[3][6:0] & {7{cin}}), cin};
    assign sum  = p[0] ^ c;
    assign cout = g[3][7] | (p[3][7] & cin);

endmodule

// File: rtl/mp_add_seq.sv
// Sequential WIDTH-bit adder: one 8-bit prefix_adder chunk per cycle, LSB first,
// with valid/ready on both sides. Define MP_ADD_SEQ_OVF_EN to add the ovf output.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef MP_ADD_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NCHUNK = nchunk(WIDTH);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH < CHUNK_W || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
        $error("mp_add_seq: WIDTH must be a multiple of 8 and at least 8");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.
    mp_state_t        state, state_next;
    logic [WIDTH-1:0] a_r, b_r, s_r, s_shift;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic             accept, step;
    logic [CHUNK_W-1:0] sum8;
    logic             cout8;

    prefix_adder u_chunk (
        .a    (a_r[CHUNK_W-1:0]),
        .b    (b_r[CHUNK_W-1:0]),
        .cin  (carry_r),
        .sum  (sum8),
        .cout (cout8)
    );

    // Each new chunk enters at the top so the LSB chunk ends up at bit 0.
    always_comb begin
        s_shift = s_r >> CHUNK_W;
        s_shift[WIDTH-1 -: CHUNK_W] = sum8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            s_r     <= '0;
            carry_r <= cin;
            idx     <= '0;
        end else if (step) begin
            a_r     <= a_r >> CHUNK_W;
            b_r     <= b_r >> CHUNK_W;
            s_r     <= s_shift;
            carry_r <= cout8;
            idx     <= idx + 1'b1;
        end
    end

    assign s    = s_r;
    assign cout = carry_r;
    assign busy = (state != IDLE);

`ifdef MP_ADD_SEQ_OVF_EN
    // Operand MSBs are gone from a_r/b_r after shifting, so keep them aside.
    logic a_msb_r, b_msb_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else if (accept) begin
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end
    end

    assign ovf = a_msb_r ^ b_msb_r ^ s_r[WIDTH-1] ^ carry_r;
`endif

endmodule
